uart_tx_fifo_feeder: RTL and testbench

Bus-mapped transmit buffer that sits directly upstream of the uart_tx serializer. The CPU pushes bytes into a DEPTH-entry FIFO over the simple read/write/addr bus. A feeder FSM pops bytes one at a time and hands each to the serializer through a one-cycle tx_dv strobe, then waits for tx_done before sending the next. This decouples software from per-byte serializer timing and adds overflow and drain status plus an interrupt.

---
 rtl/uart_tx_fifo_feeder_if.sv | 25 ++
 rtl/uart_tx_fifo_feeder.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_feeder_if.sv
// Bus and serializer-side signals of the UART transmit FIFO feeder.
// The master side is the CPU bus plus the serializer; the slave side is the feeder itself.
interface uart_tx_fifo_feeder_if;
  logic       read;
  logic       write;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       irq;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;

  modport master (
    output read, write, addr, data_in, tx_active, tx_done,
    input  data_out, ready, irq, tx_dv, tx_byte
  );

  modport slave (
    input  read, write, addr, data_in, tx_active, tx_done,
    output data_out, ready, irq, tx_dv, tx_byte
  );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Bus-mapped transmit FIFO that feeds the uart_tx serializer one byte per tx_dv/tx_done
// handshake, with overflow/drain status and a drain interrupt.
module uart_tx_fifo_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  uart_tx_fifo_feeder_if.slave bus
);
  localparam logic [PTR_W:0]   CountFull = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CountOne  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  typedef enum logic [1:0] {StIdle, StPulse, StWaitDone} state_e;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             enable_q, irq_en_q, overflow_q, drained_q;
  logic [7:0]       tx_byte_q, data_out_q, rd_data;
  state_e           state_q, state_d;
  logic             full, empty, busy;
  logic             push_req, push, ctrl_wr, flush, clr, pop, drained_set;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  assign push_req = bus.write && (bus.addr == 3'd0);
  assign push     = push_req && !full;
  assign ctrl_wr  = bus.write && (bus.addr == 3'd4);
  assign flush    = ctrl_wr && bus.data_in[1];
  assign clr      = ctrl_wr && bus.data_in[2];

  // Feeder FSM; the tx_active check in StIdle skips the serializer's cleanup cycle.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    drained_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_q && !empty && !bus.tx_active && !flush) begin
          pop     = 1'b1;
          state_d = StPulse;
        end
      end
      StPulse:    state_d = StWaitDone;
      StWaitDone: begin
        if (bus.tx_done) begin
          state_d     = StIdle;
          drained_set = empty && !push;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop)      count_d = count_q + CountOne;
      else if (pop && !push) count_d = count_q - CountOne;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.addr)
      3'd4:    rd_data = {3'b000, drained_q, overflow_q, busy, full, empty};
      3'd2:    rd_data = 8'(count_q);
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      data_out_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (ctrl_wr) begin
        enable_q <= bus.data_in[0];
        irq_en_q <= bus.data_in[3];
      end
      if (pop)      tx_byte_q  <= mem[rd_ptr_q];
      if (bus.read) data_out_q <= rd_data;
      // Set events take priority over a same-edge clear.
      overflow_q <= (push_req && full) || (overflow_q && !clr);
      drained_q  <= drained_set || (drained_q && !clr);
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = !full;
  assign bus.irq      = drained_q && irq_en_q;
  assign bus.tx_dv    = (state_q == StPulse);
  assign bus.tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder: bus pushes, serializer handshake model,
// overflow, flush, pointer wrap, interrupt and asynchronous reset.
module tb_uart_tx_fifo_feeder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   dv_viol = 0;
  bit   pending = 1'b0;
  logic [7:0] dv_log [$];
  logic [7:0] rd;
  int   n0;
  int   ff;

  uart_tx_fifo_feeder_if bus ();

  uart_tx_fifo_feeder #(.DEPTH(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Logs every tx_dv and flags two starts without an intervening tx_done.
  always @(negedge clk) begin
    if (bus.tx_done) pending = 1'b0;
    if (bus.tx_dv) begin
      dv_log.push_back(bus.tx_byte);
      if (pending) dv_viol++;
      pending = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a negedge.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus.write = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    bus.read = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.data_out;
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (bus.tx_dv !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_dv"}, 32'(bus.tx_dv), 32'd1);
  endtask

  // Serializer model: accept the byte, optionally push another mid-byte, then tx_done.
  task automatic send_one(input logic [7:0] exp, input int lat, input int cleanup,
                          input bit do_push, input logic [7:0] pb, input string tag);
    wait_dv(tag);
    check({tag, "_byte"}, 32'(bus.tx_byte), 32'(exp));
    bus.tx_active = 1'b1;
    if (do_push) begin
      bus_write(3'd0, pb);
      repeat (lat - 1) @(negedge clk);
    end else begin
      repeat (lat) @(negedge clk);
    end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    for (int i = 0; i < cleanup; i++) begin
      @(negedge clk);
      check({tag, "_cleanup"}, 32'(bus.tx_dv), 32'd0);
    end
    bus.tx_active = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = 3'd0; bus.data_in = 8'h00;
    bus.tx_active = 1'b0; bus.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'h00);
    check("rst_tx_dv", 32'(bus.tx_dv), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_irq", 32'(bus.irq), 32'd0);
    rst = 1'b0;
    bus_read(3'd4, rd); check("rst_status", 32'(rd), 32'h01);
    bus_read(3'd2, rd); check("rst_count", 32'(rd), 32'h00);

    // Single byte with latency check.
    bus_write(3'd4, 8'h01);
    bus_write(3'd0, 8'hA5);
    check("t1_dv_early", 32'(bus.tx_dv), 32'd0);
    @(negedge clk);
    check("t1_dv_latency", 32'(bus.tx_dv), 32'd1);
    send_one(8'hA5, 20, 0, 1'b0, 8'h00, "t1");
    bus_read(3'd4, rd); check("t1_status", 32'(rd), 32'h11);
    check("t1_dv_count", 32'(dv_log.size()), 32'd1);

    // Burst with backpressure and overflow.
    bus_write(3'd4, 8'h04);
    for (int i = 0; i < 8; i++) bus_write(3'd0, 8'(8'h10 + i));
    check("t2_ready_full", 32'(bus.ready), 32'd0);
    bus_read(3'd2, rd); check("t2_count8", 32'(rd), 32'h08);
    bus_write(3'd0, 8'hFF);
    bus_read(3'd4, rd); check("t2_status_ovf", 32'(rd), 32'h0A);
    n0 = dv_log.size();
    bus_write(3'd4, 8'h01);
    for (int i = 0; i < 8; i++) send_one(8'(8'h10 + i), 3, 0, 1'b0, 8'h00, $sformatf("t2_%0d", i));
    repeat (3) @(negedge clk);
    check("t2_dv_count", 32'(dv_log.size() - n0), 32'd8);
    ff = 0;
    for (int k = n0; k < dv_log.size(); k++) if (dv_log[k] == 8'hFF) ff++;
    check("t2_no_ff", 32'(ff), 32'd0);
    bus_read(3'd2, rd); check("t2_count0", 32'(rd), 32'h00);
    bus_read(3'd4, rd); check("t2_status_end", 32'(rd), 32'h19);

    // Cleanup guard: tx_active lingers one cycle after tx_done.
    bus_write(3'd4, 8'h05);
    bus_write(3'd0, 8'h21);
    bus_write(3'd0, 8'h22);
    send_one(8'h21, 4, 1, 1'b0, 8'h00, "t3a");
    send_one(8'h22, 4, 1, 1'b0, 8'h00, "t3b");
    bus_read(3'd2, rd); check("t3_count0", 32'(rd), 32'h00);
    bus_read(3'd4, rd); check("t3_status", 32'(rd), 32'h11);

    // Flush during WAIT_DONE of the first byte.
    bus_write(3'd4, 8'h04);
    for (int i = 0; i < 4; i++) bus_write(3'd0, 8'(8'h31 + i));
    bus_read(3'd2, rd); check("t4_count4", 32'(rd), 32'h04);
    n0 = dv_log.size();
    bus_write(3'd4, 8'h01);
    wait_dv("t4");
    check("t4_byte", 32'(bus.tx_byte), 32'h31);
    bus.tx_active = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(3'd4, 8'h03);
    repeat (2) @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0; bus.tx_active = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_dv_count", 32'(dv_log.size() - n0), 32'd1);
    bus_read(3'd2, rd); check("t4_count0", 32'(rd), 32'h00);
    bus_read(3'd4, rd); check("t4_status", 32'(rd), 32'h11);

    // Pointer wrap: 13 bytes, pushes interleaved with the drain.
    bus_write(3'd4, 8'h00);
    for (int i = 0; i < 6; i++) bus_write(3'd0, 8'(8'h40 + i));
    bus_read(3'd2, rd); check("t5_count6", 32'(rd), 32'h06);
    bus_write(3'd4, 8'h01);
    for (int i = 0; i < 13; i++) begin
      send_one(8'(8'h40 + i), 3, 0, (i < 7), 8'(8'h46 + i), $sformatf("t5_%0d", i));
      if (i == 6) begin
        bus_read(3'd2, rd); check("t5_count_mid", 32'(rd), 32'h06);
      end
    end
    bus_read(3'd2, rd); check("t5_count0", 32'(rd), 32'h00);
    bus_read(3'd4, rd); check("t5_status", 32'(rd), 32'h11);

    // Interrupt, sticky clear, then reset during PULSE.
    bus_write(3'd4, 8'h0D);
    check("t6_irq_clr0", 32'(bus.irq), 32'd0);
    bus_write(3'd0, 8'h55);
    send_one(8'h55, 3, 0, 1'b0, 8'h00, "t6");
    check("t6_irq_set", 32'(bus.irq), 32'd1);
    bus_write(3'd4, 8'h0D);
    check("t6_irq_clr", 32'(bus.irq), 32'd0);
    bus_write(3'd0, 8'h66);
    @(negedge clk);
    check("t6_pulse", 32'(bus.tx_dv), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dv", 32'(bus.tx_dv), 32'd0);
    check("t6_rst_ready", 32'(bus.ready), 32'd1);
    check("t6_rst_data_out", 32'(bus.data_out), 32'h00);
    check("t6_rst_tx_byte", 32'(bus.tx_byte), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    bus_read(3'd4, rd); check("t6_status", 32'(rd), 32'h01);
    check("t6_irq_after", 32'(bus.irq), 32'd0);
    check("dv_handshake", 32'(dv_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
